// File: rtl/smc_access_ctrl_lite_pkg.sv
// Shared definitions for the SMC lite access sequencer.
//   - smc_state_e : sequencer states (idle, strobe, hold)
//   - SZ_*        : AHB transfer size codes
//   - CNT_W       : width of the wait-state and hold counters
//   - size_bytes  : bytes covered by a transfer size code (code 3 behaves as a word)
//   - last_beat   : index of the final external beat for a size on a given bus width
package smc_defs_lite;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StHold   = 2'd2
  } smc_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    n = 3'd4;
    if (sz == SZ_BYTE) n = 3'd1;
    if (sz == SZ_HALF) n = 3'd2;
    return n;
  endfunction

  function automatic logic [1:0] last_beat(input logic [1:0] sz, input int unsigned mem_bytes);
    int unsigned n;
    n = 32'(size_bytes(sz));
    if (n <= mem_bytes) return 2'd0;
    return 2'(n / mem_bytes - 1);
  endfunction

endpackage

// File: rtl/smc_access_ctrl_lite_if.sv
// AHB-side request/response and external static-memory signals of the SMC lite sequencer.
//   master : upstream AHB logic plus the external memory (drives requests and smc_data_in)
//   slave  : the sequencer (drives status, read_data and all external strobes)
interface smc_access_ctrl_lite_if #(
  parameter int unsigned MEM_BYTES = 2
);
  logic                   new_access;
  logic                   n_read;
  logic [1:0]             xfer_size;
  logic [31:0]            addr;
  logic [31:0]            write_data;
  logic [8*MEM_BYTES-1:0] smc_data_in;
  logic                   smc_idle;
  logic                   smc_done;
  logic                   mac_done;
  logic [31:0]            read_data;
  logic [31:0]            smc_addr;
  logic                   smc_n_cs;
  logic                   smc_n_oe;
  logic                   smc_n_we;
  logic [MEM_BYTES-1:0]   smc_n_be;
  logic [8*MEM_BYTES-1:0] smc_data_out;

  modport master (
    output new_access, n_read, xfer_size, addr, write_data, smc_data_in,
    input  smc_idle, smc_done, mac_done, read_data, smc_addr,
    input  smc_n_cs, smc_n_oe, smc_n_we, smc_n_be, smc_data_out
  );

  modport slave (
    input  new_access, n_read, xfer_size, addr, write_data, smc_data_in,
    output smc_idle, smc_done, mac_done, read_data, smc_addr,
    output smc_n_cs, smc_n_oe, smc_n_we, smc_n_be, smc_data_out
  );
endinterface

// File: rtl/smc_lane_steer_lite.sv
// Combinational byte-lane steering between the 32-bit AHB word and the external bus.
//   i_beat_off : byte position of the current beat within the 32-bit word
//   i_acc_off  : low address bits of the access
//   i_size     : transfer size code
//   i_strobe   : byte enables are only asserted while strobing
//   i_wdata    : latched AHB write data       -> o_wdata  : external write lanes
//   i_rdata    : external read data           -> o_rdata  : read bytes placed in word position
//   o_rd_en    : which read_data bytes this beat updates
//   o_n_be     : active-low byte enables for the lanes the access covers
module smc_lane_steer_lite
  import smc_defs_lite::*;
#(
  parameter int unsigned MEM_BYTES = 2
) (
  input  logic [1:0]             i_beat_off,
  input  logic [1:0]             i_acc_off,
  input  logic [1:0]             i_size,
  input  logic                   i_strobe,
  input  logic [31:0]            i_wdata,
  input  logic [8*MEM_BYTES-1:0] i_rdata,
  output logic [8*MEM_BYTES-1:0] o_wdata,
  output logic [31:0]            o_rdata,
  output logic [3:0]             o_rd_en,
  output logic [MEM_BYTES-1:0]   o_n_be
);

  logic [2:0] w_nbytes;
  logic [1:0] w_size_mask;
  logic [1:0] w_acc_lo;
  logic [2:0] w_pos;

  always_comb begin
    w_nbytes    = size_bytes(i_size);
    // nbytes-1 in two bits; a word wraps to 2'b11 so its offset clears to 0
    w_size_mask = w_nbytes[1:0] - 2'd1;
    w_acc_lo    = i_acc_off & ~w_size_mask;
    w_pos       = '0;
    o_wdata     = '0;
    o_n_be      = '1;
    o_rdata     = '0;
    o_rd_en     = '0;
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      w_pos = {1'b0, i_beat_off} + 3'(i);
      o_wdata[8*i +: 8] = i_wdata[8*w_pos[1:0] +: 8];
      if (i_strobe && (w_pos >= {1'b0, w_acc_lo}) && (w_pos < ({1'b0, w_acc_lo} + w_nbytes))) begin
        o_n_be[i] = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(i_beat_off)) && (k < int'(i_beat_off) + int'(MEM_BYTES))) begin
        o_rd_en[k]        = 1'b1;
        o_rdata[8*k +: 8] = i_rdata[8*(k - int'(i_beat_off)) +: 8];
      end
    end
  end

endmodule

// File: rtl/smc_access_ctrl_lite.sv
// Static-memory access sequencer for the SMC lite path.
//   hclk        : system clock
//   n_sys_reset : asynchronous active-low reset
//   bus         : slave view of smc_access_ctrl_lite_if (AHB request/response + external strobes)
// Each AHB access becomes one or more external beats; each beat is a strobe phase of
// WS_RD/WS_WR+1 cycles followed by HOLD cycles with chip select still low.
module smc_access_ctrl_lite
  import smc_defs_lite::*;
#(
  parameter int unsigned MEM_BYTES = 2,
  parameter int unsigned WS_RD     = 2,
  parameter int unsigned WS_WR     = 1,
  parameter int unsigned HOLD      = 1
) (
  input logic                   hclk,
  input logic                   n_sys_reset,
  smc_access_ctrl_lite_if.slave bus
);

  localparam logic [CNT_W-1:0] WsRd   = CNT_W'(WS_RD);
  localparam logic [CNT_W-1:0] WsWr   = CNT_W'(WS_WR);
  localparam logic [CNT_W-1:0] HoldM1 = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  smc_state_e       r_state, w_state_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic             r_n_read, w_n_read_nxt;
  logic [1:0]       r_size, w_size_nxt;
  logic [1:0]       r_beat_idx, w_beat_idx_nxt;
  logic [1:0]       r_last_idx, w_last_idx_nxt;
  logic [CNT_W-1:0] r_ws_cnt, w_ws_cnt_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [31:0]      r_rdata;

  logic        w_done;
  logic        w_last;
  logic        w_accept;
  logic        w_capture;
  logic [31:0] w_beat_addr;
  logic [31:0] w_rd_spread;
  logic [3:0]  w_rd_en;

  assign w_done      = (r_state == StHold) && (r_hold_cnt == '0);
  assign w_last      = (r_beat_idx == r_last_idx);
  // Accepted when idle, or in the final done cycle for back-to-back accesses
  assign w_accept    = bus.new_access && ((r_state == StIdle) || (w_done && w_last));
  assign w_capture   = (r_state == StStrobe) && (r_ws_cnt == '0) && !r_n_read;
  assign w_beat_addr = (r_addr & ~(32'(MEM_BYTES) - 32'd1)) + (32'(r_beat_idx) * 32'(MEM_BYTES));

  smc_lane_steer_lite #(
    .MEM_BYTES (MEM_BYTES)
  ) u_steer (
    .i_beat_off (w_beat_addr[1:0]),
    .i_acc_off  (r_addr[1:0]),
    .i_size     (r_size),
    .i_strobe   (r_state == StStrobe),
    .i_wdata    (r_wdata),
    .i_rdata    (bus.smc_data_in),
    .o_wdata    (bus.smc_data_out),
    .o_rdata    (w_rd_spread),
    .o_rd_en    (w_rd_en),
    .o_n_be     (bus.smc_n_be)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_n_read_nxt   = r_n_read;
    w_size_nxt     = r_size;
    w_beat_idx_nxt = r_beat_idx;
    w_last_idx_nxt = r_last_idx;
    w_ws_cnt_nxt   = r_ws_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    unique case (r_state)
      StIdle: ;
      StStrobe: begin
        if (r_ws_cnt == '0) begin
          w_state_nxt    = StHold;
          w_hold_cnt_nxt = HoldM1;
        end else begin
          w_ws_cnt_nxt = r_ws_cnt - CntOne;
        end
      end
      StHold: begin
        if (r_hold_cnt != '0) begin
          w_hold_cnt_nxt = r_hold_cnt - CntOne;
        end else if (!w_last) begin
          w_beat_idx_nxt = r_beat_idx + 2'd1;
          w_ws_cnt_nxt   = r_n_read ? WsWr : WsRd;
          w_state_nxt    = StStrobe;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_accept) begin
      w_state_nxt    = StStrobe;
      w_addr_nxt     = bus.addr;
      w_wdata_nxt    = bus.write_data;
      w_n_read_nxt   = bus.n_read;
      w_size_nxt     = bus.xfer_size;
      w_beat_idx_nxt = 2'd0;
      w_last_idx_nxt = last_beat(bus.xfer_size, MEM_BYTES);
      w_ws_cnt_nxt   = bus.n_read ? WsWr : WsRd;
    end
  end

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_n_read   <= 1'b0;
      r_size     <= SZ_BYTE;
      r_beat_idx <= '0;
      r_last_idx <= '0;
      r_ws_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_n_read   <= w_n_read_nxt;
      r_size     <= w_size_nxt;
      r_beat_idx <= w_beat_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_ws_cnt   <= w_ws_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      if (w_capture) begin
        for (int k = 0; k < 4; k++) begin
          if (w_rd_en[k]) r_rdata[8*k +: 8] <= w_rd_spread[8*k +: 8];
        end
      end
    end
  end

  assign bus.smc_idle  = (r_state == StIdle);
  assign bus.smc_done  = w_done;
  assign bus.mac_done  = w_done && w_last;
  assign bus.read_data = r_rdata;
  assign bus.smc_addr  = w_beat_addr;
  assign bus.smc_n_cs  = (r_state == StIdle);
  assign bus.smc_n_oe  = !((r_state == StStrobe) && !r_n_read);
  assign bus.smc_n_we  = !((r_state == StStrobe) && r_n_read);

endmodule

// File: tb/tb_smc_access_ctrl_lite.sv
// Self-checking bench for smc_access_ctrl_lite: directed cases followed by random accesses,
// each checked cycle by cycle against a timeline computed from beat/wait/hold arithmetic.
module tb_smc_access_ctrl_lite;

  localparam int unsigned MB    = 2;
  localparam int unsigned WS_RD = 2;
  localparam int unsigned WS_WR = 1;
  localparam int unsigned HOLD  = 1;

  logic hclk = 1'b0;
  logic n_sys_reset;

  smc_access_ctrl_lite_if #(.MEM_BYTES(MB)) bus ();

  smc_access_ctrl_lite #(
    .MEM_BYTES (MB),
    .WS_RD     (WS_RD),
    .WS_WR     (WS_WR),
    .HOLD      (HOLD)
  ) dut (
    .hclk        (hclk),
    .n_sys_reset (n_sys_reset),
    .bus         (bus)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic noise();
    bus.new_access = 1'($urandom_range(0, 1));
    bus.n_read     = 1'($urandom_range(0, 1));
    bus.xfer_size  = 2'($urandom_range(0, 3));
    bus.addr       = $urandom;
    bus.write_data = $urandom;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_idle"}, 32'(bus.smc_idle), 32'd1);
    chk({tag, "_ncs"}, 32'(bus.smc_n_cs), 32'd1);
    chk({tag, "_noe"}, 32'(bus.smc_n_oe), 32'd1);
    chk({tag, "_nwe"}, 32'(bus.smc_n_we), 32'd1);
    chk({tag, "_nbe"}, 32'(bus.smc_n_be), 32'((1 << MB) - 1));
    chk({tag, "_done"}, 32'(bus.smc_done), 32'd0);
    chk({tag, "_mac"}, 32'(bus.mac_done), 32'd0);
    chk({tag, "_rdata"}, bus.read_data, exp_rdata);
  endtask

  // Drives the request in the current cycle and follows the access to its final done
  // cycle, where it returns with new_access low so the caller may chain the next one.
  task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] din_all);
    int nbytes, beats, ws;
    logic [31:0] base, baddr, lane_addr;
    logic [MB-1:0] exp_be;
    logic [8*MB-1:0] exp_dout, din;
    logic fin;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    beats  = (nbytes > int'(MB)) ? nbytes / int'(MB) : 1;
    ws     = wr ? int'(WS_WR) : int'(WS_RD);
    base   = a & ~(32'(MB) - 32'd1);
    bus.new_access = 1'b1;
    bus.n_read     = wr;
    bus.xfer_size  = sz;
    bus.addr       = a;
    bus.write_data = wd;
    for (int b = 0; b < beats; b++) begin
      baddr = base + 32'(b) * 32'(MB);
      din   = din_all[8*MB*b +: 8*MB];
      bus.smc_data_in = din;
      exp_be   = '1;
      exp_dout = '0;
      for (int i = 0; i < int'(MB); i++) begin
        lane_addr = baddr + 32'(i);
        if ((lane_addr - a) < 32'(nbytes)) exp_be[i] = 1'b0;
        exp_dout[8*i +: 8] = wd[8*int'(lane_addr[1:0]) +: 8];
      end
      for (int c = 0; c <= ws; c++) begin
        cyc();
        chk("st_idle", 32'(bus.smc_idle), 32'd0);
        chk("st_addr", bus.smc_addr, baddr);
        chk("st_ncs", 32'(bus.smc_n_cs), 32'd0);
        chk("st_noe", 32'(bus.smc_n_oe), 32'(wr));
        chk("st_nwe", 32'(bus.smc_n_we), 32'(!wr));
        chk("st_nbe", 32'(bus.smc_n_be), 32'(exp_be));
        chk("st_done", 32'(bus.smc_done), 32'd0);
        chk("st_mac", 32'(bus.mac_done), 32'd0);
        chk("st_rdata", bus.read_data, exp_rdata);
        if (wr) chk("st_dout", 32'(bus.smc_data_out), 32'(exp_dout));
        noise();
      end
      // Read data lands on the edge that ends the strobe
      if (!wr) begin
        for (int i = 0; i < int'(MB); i++) begin
          lane_addr = baddr + 32'(i);
          exp_rdata[8*int'(lane_addr[1:0]) +: 8] = din[8*i +: 8];
        end
      end
      for (int h = 0; h < int'(HOLD); h++) begin
        cyc();
        fin = (h == int'(HOLD) - 1) && (b == beats - 1);
        chk("hd_idle", 32'(bus.smc_idle), 32'd0);
        chk("hd_addr", bus.smc_addr, baddr);
        chk("hd_ncs", 32'(bus.smc_n_cs), 32'd0);
        chk("hd_noe", 32'(bus.smc_n_oe), 32'd1);
        chk("hd_nwe", 32'(bus.smc_n_we), 32'd1);
        chk("hd_nbe", 32'(bus.smc_n_be), 32'((1 << MB) - 1));
        chk("hd_done", 32'(bus.smc_done), 32'(h == int'(HOLD) - 1));
        chk("hd_mac", 32'(bus.mac_done), 32'(fin));
        chk("hd_rdata", bus.read_data, exp_rdata);
        if (wr) chk("hd_dout", 32'(bus.smc_data_out), 32'(exp_dout));
        if (fin) bus.new_access = 1'b0;
        else noise();
      end
    end
  endtask

  initial begin
    logic        r_wr;
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    int          r_nb;

    n_sys_reset     = 1'b0;
    bus.new_access  = 1'b0;
    bus.n_read      = 1'b0;
    bus.xfer_size   = 2'd0;
    bus.addr        = '0;
    bus.write_data  = '0;
    bus.smc_data_in = '0;
    #1;
    check_idle("rst");
    chk("rst_addr", bus.smc_addr, 32'd0);
    chk("rst_dout", 32'(bus.smc_data_out), 32'd0);
    #20 n_sys_reset = 1'b1;
    cyc();
    check_idle("post_rst");

    // Halfword read of 0x1002
    access(1'b0, 2'd1, 32'h0000_1002, 32'h0, 32'h0000_BEEF);
    chk("half_rd_upper", 32'(bus.read_data[31:16]), 32'h0000_BEEF);
    cyc();
    check_idle("half_rd_end");

    // Word read of 0x2000 over two beats
    access(1'b0, 2'd2, 32'h0000_2000, 32'h0, 32'h2222_1111);
    chk("word_rd_val", bus.read_data, 32'h2222_1111);
    cyc();
    check_idle("word_rd_end");

    // Reset asserted in cycle 2 of a word read
    bus.new_access  = 1'b1;
    bus.n_read      = 1'b0;
    bus.xfer_size   = 2'd2;
    bus.addr        = 32'h0000_6000;
    bus.smc_data_in = 16'h1234;
    cyc();
    bus.new_access = 1'b0;
    chk("mid_rst_c1_ncs", 32'(bus.smc_n_cs), 32'd0);
    cyc();
    chk("mid_rst_c2_noe", 32'(bus.smc_n_oe), 32'd0);
    n_sys_reset = 1'b0;
    #1;
    exp_rdata = '0;
    check_idle("mid_rst");
    chk("mid_rst_addr", bus.smc_addr, 32'd0);
    #2 n_sys_reset = 1'b1;
    cyc();
    check_idle("mid_rst_after");
    access(1'b0, 2'd2, 32'h0000_6000, 32'h0, 32'h5678_9ABC);
    chk("mid_rst_rd_val", bus.read_data, 32'h5678_9ABC);
    cyc();
    check_idle("mid_rst_rd_end");

    // Byte write then back-to-back read, with no idle cycle between them
    access(1'b1, 2'd0, 32'h0000_3001, 32'h0000_AB00, 32'h0);
    access(1'b0, 2'd1, 32'h0000_4000, 32'h0, 32'h0000_7E57);
    cyc();
    check_idle("b2b_end");

    // Word write of 0x5000 over two beats
    access(1'b1, 2'd2, 32'h0000_5000, 32'hCAFE_F00D, 32'h0);
    cyc();
    check_idle("word_wr_end");

    for (int n = 0; n < 60; n++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_nb = (r_sz == 2'd0) ? 1 : (r_sz == 2'd1) ? 2 : 4;
      r_a  = $urandom & ~(32'(r_nb) - 32'd1);
      if ($urandom_range(0, 1) == 0) begin
        cyc();
        check_idle("rnd_gap");
      end
      access(r_wr, r_sz, r_a, $urandom, $urandom);
    end
    cyc();
    check_idle("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
